jtag_scan_sequencer: RTL and testbench
======================================

Name: jtag_scan_sequencer

Overview:
- JTAG master that drives a TAP controller's TCK/TMS/TDI pins and samples TDO to run complete IR scans, DR scans and TAP resets from single commands.
- Sits between a host/command port and the test-access pins of the TAP; it is the sequencing counterpart of the TAP state machine.
- Every scan starts and ends in Run-Test/Idle.

Parameters:
- MAX_LEN, 32, maximum scan length in bits; width of CMD_DATA/RSP_DATA.
- LEN_W, 6, width of CMD_LEN; must hold MAX_LEN.

Ports:
- CLK  in  1  system clock; TCK_O is generated as CLK/2.
- TRST  in  1  reset, asynchronous, active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_IR  in  1  1 = IR scan, 0 = DR scan.
- CMD_RESET  in  1  1 = TAP reset sequence; overrides CMD_IR/LEN/DATA.
- CMD_LEN  in  LEN_W  number of bits to shift, valid range 1..MAX_LEN.
- CMD_DATA  in  MAX_LEN  TDI bits, LSB shifted first.
- RSP_VALID  out  1  one-CLK pulse, command complete.
- RSP_DATA  out  MAX_LEN  captured TDO bits, LSB first; bits at or above LEN are 0.
- TCK_O  out  1  JTAG test clock.
- TMS_O  out  1  JTAG mode select.
- TDI_O  out  1  JTAG data in to target.
- TDO_I  in  1  JTAG data out from target.

Behaviour:
- TRST=1 values: TCK_O=0, TMS_O=1, TDI_O=0, CMD_READY=0, RSP_VALID=0, RSP_DATA=0; state INIT. Applies immediately, including mid-scan; any partial command is discarded with no response.
- TCK generation: phase bit toggles every CLK while a sequence is active.
  - TCK_O rises on phase 0->1. TDO_I is sampled on this CLK edge.
  - TCK_O falls on phase 1->0. TMS_O/TDI_O update on this CLK edge, so they are stable a full half-period before the next rise.
  - When idle, TCK_O is parked at 0.
- Edge numbering: edge k means the k-th TCK rising edge of a command.
- INIT: after TRST release, issue one TCK period with TMS_O=0 (Test-Logic-Reset -> Run-Test/Idle), then go to IDLE.
- IDLE: CMD_READY=1. Command accepted on CMD_VALID && CMD_READY; all CMD_* fields are latched and CMD_READY drops the next cycle.
- PRE (header TMS bits):
  - DR scan: edges 1..3 use TMS 1,0,0.
  - IR scan: edges 1..4 use TMS 1,1,0,0.
- SHIFT: LEN edges. TDI_O = DATA[i] and TDO_I is sampled into RSP_DATA[i] at the i-th shift edge (i = 0..LEN-1). TMS_O=0 except on the last shift edge, where TMS_O=1 (-> Exit1).
- POST: two edges with TMS 1,0 (-> Update -> Run-Test/Idle).
- Totals: DR scan = LEN+5 edges; IR scan = LEN+6 edges.
- RESET command: 6 edges with TMS 1,1,1,1,1,0; RSP_DATA=0.
- RESP: in the CLK cycle after the final TCK falling edge, RSP_VALID=1 for exactly one cycle and CMD_READY=1 in that same cycle. A command presented then is accepted, giving back-to-back operation.
- RSP_DATA holds its value until the next response.
- CMD_LEN=0 or CMD_LEN>MAX_LEN: no TCK activity; RSP_VALID the next cycle with RSP_DATA=0.
- TDI_O=0 outside SHIFT.
- CMD_VALID while CMD_READY=0 is ignored; it is not queued.

Optional Feature:
- Macro: JTAG_SEQ_STATE_MIRROR_EN.
- Defined: adds output TAP_STATE[3:0], a shadow model of the target TAP updated on each TCK rise using the encoding:
  - 0 Test-Logic-Reset, 1 Run-Test/Idle, 2 Select-DR, 3 Capture-DR, 4 Shift-DR, 5 Exit1-DR, 6 Pause-DR, 7 Exit2-DR, 8 Update-DR,
  - 9 Select-IR, 10 Capture-IR, 11 Shift-IR, 12 Exit1-IR, 13 Pause-IR, 14 Exit2-IR, 15 Update-IR.
  - TAP_STATE resets to 0 on TRST.
- Not defined: no TAP_STATE port and no mirror logic.

Test Plan:
- DR scan, LEN=8, DATA=0xA5, TAP model DR preloaded 0x3C -> 13 TCK rises with TMS 1,0,0,0,0,0,0,0,0,0,1,1,0; RSP_DATA=0x3C; model DR=0xA5; exactly one RSP_VALID pulse.
- IR scan, LEN=4, DATA=0xE -> 10 rises with TMS 1,1,0,0,0,0,0,1,1,0; TDI on shift edges 0,1,1,1; RSP_DATA = model capture value; model IR=0xE.
- RESET command -> 6 rises with TMS 1,1,1,1,1,0; model ends in Run-Test/Idle; RSP_DATA=0.
- CMD_LEN=0, then CMD_LEN=MAX_LEN+1 -> no TCK edges; RSP_VALID one cycle after acceptance; RSP_DATA=0.
- TRST asserted at shift edge 3 of a 16-bit DR scan -> outputs at reset values in the same cycle, no RSP_VALID; after release, one rise with TMS=0, then CMD_READY=1.
- Two DR scans back-to-back (second CMD_VALID held high) -> second accepted in the RSP_VALID cycle. With JTAG_SEQ_STATE_MIRROR_EN: TAP_STATE=4 during shift and 1 after each scan.

Source files
------------

// File: rtl/jtag_scan_sequencer.sv
// JTAG scan sequencer: runs IR/DR scans and TAP resets on TCK/TMS/TDI/TDO.
// Optional JTAG_SEQ_STATE_MIRROR_EN adds a TAP_STATE shadow of the target.
module jtag_scan_sequencer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               CLK,
  input  logic               TRST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic               CMD_IR,
  input  logic               CMD_RESET,
  input  logic [LEN_W-1:0]   CMD_LEN,
  input  logic [MAX_LEN-1:0] CMD_DATA,
  output logic               RSP_VALID,
  output logic [MAX_LEN-1:0] RSP_DATA,
  output logic               TCK_O,
  output logic               TMS_O,
  output logic               TDI_O,
  input  logic               TDO_I
`ifdef JTAG_SEQ_STATE_MIRROR_EN
  ,
  output logic [3:0]         TAP_STATE
`endif
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int EW = LEN_W + 2;

  typedef enum logic [1:0] {
    S_INIT, S_IDLE, S_RUN, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_DR, OP_IR, OP_RST, OP_INI
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d, op_n;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic [EW-1:0]      e_q, e_d;
  logic               ph_q, ph_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  logic          rdy;
  logic          acc;
  logic          bad_len;
  logic [EW-1:0] pre_c;
  logic [EW-1:0] i_c;
  logic [EW-1:0] last_c;
  logic          sh;
  logic [1:0]    nb;

  // TMS/TDI for edge e (0-based) of a command
  function automatic logic [1:0] edge_bits(
    input op_t              op,
    input logic [EW-1:0]    e,
    input logic [LEN_W-1:0] len,
    input logic [MAX_LEN-1:0] dat
  );
    logic [EW-1:0] pre;
    logic [EW-1:0] i;
    logic          tms;
    logic          tdi;
    pre = (op == OP_IR) ? EW'(4) : EW'(3);
    i   = e - pre;
    tms = 1'b0;
    tdi = 1'b0;
    case (op)
      OP_RST: tms = (e < EW'(5));
      OP_INI: tms = 1'b0;
      default: begin
        if (e < pre) begin
          tms = (op == OP_IR) ? (e < EW'(2)) : (e == EW'(0));
        end else if (i < EW'(len)) begin
          tms = (i == EW'(len) - EW'(1));
          tdi = dat[i[IW-1:0]];
        end else begin
          tms = (i == EW'(len));
        end
      end
    endcase
    return {tms, tdi};
  endfunction

  assign rdy     = (state_q == S_IDLE) || (state_q == S_RESP);
  assign acc     = CMD_VALID && rdy;
  assign op_n    = CMD_RESET ? OP_RST : (CMD_IR ? OP_IR : OP_DR);
  assign bad_len = (CMD_LEN == '0) || (CMD_LEN > LEN_W'(MAX_LEN));

  assign pre_c  = (op_q == OP_IR) ? EW'(4) : EW'(3);
  assign i_c    = e_q - pre_c;
  assign sh     = ((op_q == OP_DR) || (op_q == OP_IR)) &&
                  (e_q >= pre_c) && (i_c < EW'(len_q));
  assign last_c = (op_q == OP_RST) ? EW'(5) :
                  (op_q == OP_INI) ? EW'(0) :
                  pre_c + EW'(len_q) + EW'(1);
  assign nb     = edge_bits(op_q, e_q + EW'(1), len_q, data_q);

  // State, command and pin registers
  always_ff @(posedge CLK or posedge TRST) begin
    if (TRST) begin
      state_q <= S_INIT;
      op_q    <= OP_DR;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      e_q     <= '0;
      ph_q    <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      e_q     <= e_d;
      ph_q    <= ph_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  // Sequencing: accept, walk edges, capture TDO, respond
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    e_d     = e_q;
    ph_d    = ph_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    unique case (state_q)
      S_INIT: begin
        state_d = S_RUN;
        op_d    = OP_INI;
        e_d     = '0;
        ph_d    = 1'b0;
        tms_d   = 1'b0;
        tdi_d   = 1'b0;
      end
      S_IDLE, S_RESP: begin
        if (acc) begin
          op_d   = op_n;
          len_d  = CMD_LEN;
          data_d = CMD_DATA;
          cap_d  = '0;
          e_d    = '0;
          ph_d   = 1'b0;
          tdi_d  = 1'b0;
          if (!CMD_RESET && bad_len) begin
            state_d = S_RESP;
            rsp_d   = '0;
            tms_d   = 1'b0;
          end else begin
            // first edge leaves Run-Test/Idle in every command
            state_d = S_RUN;
            tms_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        ph_d = ~ph_q;
        if (!ph_q) begin
          if (sh) cap_d[i_c[IW-1:0]] = TDO_I;
        end else if (e_q == last_c) begin
          tms_d = 1'b0;
          tdi_d = 1'b0;
          if (op_q == OP_INI) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
            rsp_d   = cap_q;
          end
        end else begin
          e_d   = e_q + EW'(1);
          tms_d = nb[1];
          tdi_d = nb[0];
        end
      end
    endcase
  end

  assign CMD_READY = rdy;
  assign RSP_VALID = (state_q == S_RESP);
  assign RSP_DATA  = rsp_q;
  assign TCK_O     = ph_q;
  assign TMS_O     = tms_q;
  assign TDI_O     = tdi_q;

`ifdef JTAG_SEQ_STATE_MIRROR_EN
  logic [3:0] tap_q, tap_d;

  function automatic logic [3:0] tap_nxt(
    input logic [3:0] s,
    input logic       m
  );
    logic [3:0] r;
    case (s)
      4'd0:    r = m ? 4'd0  : 4'd1;
      4'd1:    r = m ? 4'd2  : 4'd1;
      4'd2:    r = m ? 4'd9  : 4'd3;
      4'd3:    r = m ? 4'd5  : 4'd4;
      4'd4:    r = m ? 4'd5  : 4'd4;
      4'd5:    r = m ? 4'd8  : 4'd6;
      4'd6:    r = m ? 4'd7  : 4'd6;
      4'd7:    r = m ? 4'd8  : 4'd4;
      4'd8:    r = m ? 4'd2  : 4'd1;
      4'd9:    r = m ? 4'd0  : 4'd10;
      4'd10:   r = m ? 4'd12 : 4'd11;
      4'd11:   r = m ? 4'd12 : 4'd11;
      4'd12:   r = m ? 4'd15 : 4'd13;
      4'd13:   r = m ? 4'd14 : 4'd13;
      4'd14:   r = m ? 4'd15 : 4'd11;
      default: r = m ? 4'd2  : 4'd1;
    endcase
    return r;
  endfunction

  // Shadow TAP advances on every TCK rise
  always_comb begin
    tap_d = tap_q;
    if ((state_q == S_RUN) && !ph_q) tap_d = tap_nxt(tap_q, tms_q);
  end

  // Shadow TAP register
  always_ff @(posedge CLK or posedge TRST) begin
    if (TRST) tap_q <= 4'd0;
    else      tap_q <= tap_d;
  end

  assign TAP_STATE = tap_q;
`endif

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer with a behavioural target TAP.
// Define JTAG_SEQ_STATE_MIRROR_EN to also check TAP_STATE.
module tb_jtag_scan_sequencer;

  logic        CLK = 1'b0;
  logic        TRST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_IR = 1'b0;
  logic        CMD_RESET = 1'b0;
  logic [5:0]  CMD_LEN = '0;
  logic [31:0] CMD_DATA = '0;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA;
  logic        TCK_O;
  logic        TMS_O;
  logic        TDI_O;
  logic        tdo = 1'b0;
`ifdef JTAG_SEQ_STATE_MIRROR_EN
  logic [3:0]  TAP_STATE;
`endif

  int total = 0;
  int bad = 0;

  jtag_scan_sequencer #(.MAX_LEN(32), .LEN_W(6)) dut (
    .CLK(CLK),
    .TRST(TRST),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_IR(CMD_IR),
    .CMD_RESET(CMD_RESET),
    .CMD_LEN(CMD_LEN),
    .CMD_DATA(CMD_DATA),
    .RSP_VALID(RSP_VALID),
    .RSP_DATA(RSP_DATA),
    .TCK_O(TCK_O),
    .TMS_O(TMS_O),
    .TDI_O(TDI_O),
    .TDO_I(tdo)
`ifdef JTAG_SEQ_STATE_MIRROR_EN
    ,
    .TAP_STATE(TAP_STATE)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // target TAP model
  logic [3:0] mst = 4'd0;
  logic [7:0] mdr = 8'h3C;
  logic [7:0] dsr = 8'h00;
  logic [3:0] mir = 4'h0;
  logic [3:0] isr = 4'h0;

  function automatic logic [3:0] tnx(input logic [3:0] s, input logic m);
    logic [3:0] t1 [16];
    logic [3:0] t0 [16];
    t0 = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
           4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
    t1 = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
           4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};
    return m ? t1[s] : t0[s];
  endfunction

  always @(posedge TCK_O or posedge TRST) begin
    if (TRST) begin
      mst <= 4'd0;
    end else begin
      case (mst)
        4'd3:  dsr <= mdr;
        4'd4:  dsr <= {TDI_O, dsr[7:1]};
        4'd8:  mdr <= dsr;
        4'd10: isr <= 4'h5;
        4'd11: isr <= {TDI_O, isr[3:1]};
        4'd15: mir <= isr;
        default: ;
      endcase
      mst <= tnx(mst, TMS_O);
    end
  end

  always @(negedge TCK_O)
    tdo <= (mst == 4'd4) ? dsr[0] : (mst == 4'd11) ? isr[0] : 1'b0;

  // pin log and response pulse counter
  int   n = 0;
  int   npulse = 0;
  logic tms_a [256];
  logic tdi_a [256];

  always @(posedge TCK_O) begin
    tms_a[n % 256] = TMS_O;
    tdi_a[n % 256] = TDI_O;
    n++;
  end

  always @(negedge CLK)
    if (RSP_VALID) npulse++;

`ifdef JTAG_SEQ_STATE_MIRROR_EN
  always @(negedge CLK)
    if (!TRST) chk("mirror", {60'd0, TAP_STATE}, {60'd0, mst});
`endif

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!CMD_READY && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, CMD_READY, 1'b1);
  endtask

  task automatic pack(input int n0, input int ne,
                      output logic [63:0] tv, output logic [63:0] dv);
    tv = '0;
    dv = '0;
    for (int j = 0; j < ne && j < 64; j++) begin
      tv = {tv[62:0], tms_a[(n0 + j) % 256]};
      dv = {dv[62:0], tdi_a[(n0 + j) % 256]};
    end
  endtask

  task automatic run_cmd(input logic rs, input logic ir,
                         input logic [5:0] len, input logic [31:0] dat,
                         output int lat, output int ne,
                         output logic [63:0] tv, output logic [63:0] dv,
                         output int np);
    int n0;
    int p0;
    wait_ready("ready");
    n0 = n;
    p0 = npulse;
    CMD_RESET = rs;
    CMD_IR    = ir;
    CMD_LEN   = len;
    CMD_DATA  = dat;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    lat = 0;
    while (!RSP_VALID && lat < 300) begin
      @(negedge CLK);
      lat++;
    end
    chk("rsp_seen", RSP_VALID, 1'b1);
    ne = n - n0;
    pack(n0, ne, tv, dv);
    repeat (3) @(negedge CLK);
    #1;
    np = npulse - p0;
  endtask

  int          lat;
  int          ne;
  int          np;
  int          n0;
  int          p0;
  int          k;
  logic [63:0] tv;
  logic [63:0] dv;

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_tck", TCK_O, 1'b0);
    chk("rst_tms", TMS_O, 1'b1);
    chk("rst_tdi", TDI_O, 1'b0);
    chk("rst_rdy", CMD_READY, 1'b0);
    chk("rst_rv", RSP_VALID, 1'b0);
    chk("rst_rd", RSP_DATA, 32'h0);

    @(negedge CLK);
    n0 = n;
    TRST = 1'b0;
    wait_ready("init_rdy");
    chk("init_edges", n - n0, 1);
    chk("init_tms", tms_a[n0 % 256], 1'b0);
    chk("init_tap", mst, 4'd1);

    // DR scan, 8 bits
    run_cmd(1'b0, 1'b0, 6'd8, 32'hA5, lat, ne, tv, dv, np);
    chk("dr_edges", ne, 13);
    chk("dr_tms", tv, 64'h1006);
    chk("dr_tdi", dv, 64'h0294);
    chk("dr_rsp", RSP_DATA, 32'h3C);
    chk("dr_model", mdr, 8'hA5);
    chk("dr_pulse", np, 1);
    chk("dr_lat", lat, 26);
    chk("dr_tap", mst, 4'd1);
    chk("dr_tdi0", TDI_O, 1'b0);

    // TAP reset command
    run_cmd(1'b1, 1'b0, 6'd3, 32'hFF, lat, ne, tv, dv, np);
    chk("rst_edges", ne, 6);
    chk("rst_tms", tv, 64'h3E);
    chk("rst_rsp", RSP_DATA, 32'h0);
    chk("rst_tap", mst, 4'd1);
    chk("rst_pulse", np, 1);
    chk("rst_lat", lat, 12);

    // IR scan, 4 bits
    run_cmd(1'b0, 1'b1, 6'd4, 32'hE, lat, ne, tv, dv, np);
    chk("ir_edges", ne, 10);
    chk("ir_tms", tv, 64'h306);
    chk("ir_tdi", dv, 64'h01C);
    chk("ir_rsp", RSP_DATA, 32'h5);
    chk("ir_model", mir, 4'hE);
    chk("ir_pulse", np, 1);
    chk("ir_lat", lat, 20);

    // out-of-range lengths
    run_cmd(1'b0, 1'b0, 6'd0, 32'hFFFF_FFFF, lat, ne, tv, dv, np);
    chk("len0_edges", ne, 0);
    chk("len0_lat", lat, 0);
    chk("len0_rsp", RSP_DATA, 32'h0);
    chk("len0_pulse", np, 1);
    run_cmd(1'b0, 1'b1, 6'd33, 32'hFFFF_FFFF, lat, ne, tv, dv, np);
    chk("len33_edges", ne, 0);
    chk("len33_lat", lat, 0);
    chk("len33_rsp", RSP_DATA, 32'h0);
    chk("len33_pulse", np, 1);

    // back-to-back DR scans
    wait_ready("b2b_rdy");
    n0 = n;
    p0 = npulse;
    CMD_RESET = 1'b0;
    CMD_IR    = 1'b0;
    CMD_LEN   = 6'd8;
    CMD_DATA  = 32'h11;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_DATA = 32'h22;
    k = 0;
    while (!RSP_VALID && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk("b2b_rv1", RSP_VALID, 1'b1);
    chk("b2b_rsp1", RSP_DATA, 32'hA5);
    chk("b2b_rdy1", CMD_READY, 1'b1);
    @(negedge CLK);
    chk("b2b_rv_lo", RSP_VALID, 1'b0);
    chk("b2b_busy", CMD_READY, 1'b0);
    CMD_VALID = 1'b0;
    k = 0;
    while (!RSP_VALID && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk("b2b_rv2", RSP_VALID, 1'b1);
    chk("b2b_rsp2", RSP_DATA, 32'h11);
    chk("b2b_edges", n - n0, 26);
    repeat (3) @(negedge CLK);
    #1;
    chk("b2b_pulse", npulse - p0, 2);
    chk("b2b_model", mdr, 8'h22);

    // TRST in the middle of a 16-bit DR scan
    wait_ready("trst_rdy");
    n0 = n;
    p0 = npulse;
    CMD_LEN   = 6'd16;
    CMD_DATA  = 32'hFFFF;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    k = 0;
    while ((n - n0) < 7 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("trst_at7", n - n0, 7);
    TRST = 1'b1;
    #1;
    chk("trst_tck", TCK_O, 1'b0);
    chk("trst_tms", TMS_O, 1'b1);
    chk("trst_tdi", TDI_O, 1'b0);
    chk("trst_rdy", CMD_READY, 1'b0);
    chk("trst_rv", RSP_VALID, 1'b0);
    chk("trst_rd", RSP_DATA, 32'h0);
    repeat (3) @(negedge CLK);
    n0 = n;
    TRST = 1'b0;
    wait_ready("trst_rel");
    chk("trst_edges", n - n0, 1);
    chk("trst_itms", tms_a[n0 % 256], 1'b0);
    chk("trst_pulse", npulse - p0, 0);
    chk("trst_tap", mst, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
